// File: rtl/elev_pkg.sv
// Shared types and defaults for the elevator request tracker.
//
// Contents:
//   dir_t             - direction of the last completed move (IDLE/UP/DOWN)
//   N_FLOORS_DEF      - default number of floors
//   TRAVEL_CYCLES_DEF - default motor-command cycles per one-floor move
//   floor_w()         - floor index width, $clog2(n) but never below 1
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_t;

    localparam int N_FLOORS_DEF      = 10;
    localparam int TRAVEL_CYCLES_DEF = 16;

    function automatic int floor_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elev_travel_timer.sv
// Travel timer: counts consecutive valid motor-command cycles and emits a
// one-cycle step pulse when a one-floor move completes.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   go_up      - motor-up command
//   go_down    - motor-down command
//   open       - door-open command (suppresses travel)
//   at_top     - car is at the highest floor (up travel blocked)
//   at_bottom  - car is at floor 0 (down travel blocked)
//   step_up    - combinational pulse: move up completes this cycle
//   step_down  - combinational pulse: move down completes this cycle
module elev_travel_timer
    import elev_pkg::*;
#(
    parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic go_up,
    input  logic go_down,
    input  logic open,
    input  logic at_top,
    input  logic at_bottom,
    output logic step_up,
    output logic step_down
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TRAVEL_CYCLES - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          move_up;
    logic          move_dn;

    always_comb begin
        // A move is only valid with exactly one command, the door shut and
        // no wall in the way; anything else discards partial travel.
        move_up   = go_up & ~go_down & ~open & ~at_top;
        move_dn   = go_down & ~go_up & ~open & ~at_bottom;
        timer_d   = '0;
        step_up   = 1'b0;
        step_down = 1'b0;
        if (move_up || move_dn) begin
            if (timer_q == LAST) begin
                step_up   = move_up;
                step_down = move_dn;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/elev_request_tracker.sv
// Elevator request tracker: latches hall and car calls, tracks the current
// floor from the controller's motor commands, and produces the request
// summary flags the controller consumes.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   button_up       - hall up-call buttons, one bit per floor (level)
//   button_down     - hall down-call buttons, one bit per floor (level)
//   button_floor    - car-panel buttons, one bit per floor (level)
//   go_up, go_down  - motor commands
//   open            - door-open command; clears requests at the current floor
//   floor_number    - current floor (registered)
//   arrive          - one-cycle pulse when floor_number changes
//   request_i       - request pending at the current floor
//   request_j_gt_i  - request pending at any floor above
//   request_j_lt_i  - request pending at any floor below
//
// Build option:
//   ELEV_DIR_CLEAR_EN - when defined, a door opening only clears the hall
//                       call matching the direction of the last move (both
//                       if the car has never moved); car calls always clear.
module elev_request_tracker
    import elev_pkg::*;
#(
    parameter int N_FLOORS      = N_FLOORS_DEF,
    parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_FLOORS-1:0]           button_up,
    input  logic [N_FLOORS-1:0]           button_down,
    input  logic [N_FLOORS-1:0]           button_floor,
    input  logic                          go_up,
    input  logic                          go_down,
    input  logic                          open,
    output logic [floor_w(N_FLOORS)-1:0]  floor_number,
    output logic                          arrive,
    output logic                          request_i,
    output logic                          request_j_gt_i,
    output logic                          request_j_lt_i
);

    localparam int FW = floor_w(N_FLOORS);
    localparam logic [FW-1:0] TOP = FW'(N_FLOORS - 1);

    logic [N_FLOORS-1:0] up_req_q,  up_req_d;
    logic [N_FLOORS-1:0] dn_req_q,  dn_req_d;
    logic [N_FLOORS-1:0] car_req_q, car_req_d;
    logic [FW-1:0]       floor_q,   floor_d;
    logic                arrive_q,  arrive_d;
    dir_t                last_dir_q, last_dir_d;

    logic                step_up;
    logic                step_down;
    logic                at_top;
    logic                at_bottom;
    logic [N_FLOORS-1:0] floor_onehot;
    logic [N_FLOORS-1:0] pend;
    logic [N_FLOORS-1:0] clr_up;
    logic [N_FLOORS-1:0] clr_dn;
    logic [N_FLOORS-1:0] clr_car;
    logic                gt_any;
    logic                lt_any;

    assign at_top       = (floor_q == TOP);
    assign at_bottom    = (floor_q == '0);
    assign floor_onehot = {{(N_FLOORS-1){1'b0}}, 1'b1} << floor_q;

    elev_travel_timer #(
        .TRAVEL_CYCLES (TRAVEL_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .go_up     (go_up),
        .go_down   (go_down),
        .open      (open),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .step_up   (step_up),
        .step_down (step_down)
    );

    // Clear masks for the floor the door is open at.
    always_comb begin
        clr_car = open ? floor_onehot : '0;
`ifdef ELEV_DIR_CLEAR_EN
        // Keep the opposite-direction hall call pending so the car still
        // serves it after reversing.
        clr_up  = (open && last_dir_q != DOWN) ? floor_onehot : '0;
        clr_dn  = (open && last_dir_q != UP)   ? floor_onehot : '0;
`else
        clr_up  = clr_car;
        clr_dn  = clr_car;
`endif
    end

    // Capture then clear, so a press at the served floor during open is lost.
    always_comb begin
        up_req_d  = (up_req_q  | button_up)    & ~clr_up;
        dn_req_d  = (dn_req_q  | button_down)  & ~clr_dn;
        car_req_d = (car_req_q | button_floor) & ~clr_car;
    end

    always_comb begin
        floor_d    = floor_q;
        last_dir_d = last_dir_q;
        arrive_d   = step_up | step_down;
        if (step_up) begin
            floor_d    = floor_q + FW'(1);
            last_dir_d = UP;
        end else if (step_down) begin
            floor_d    = floor_q - FW'(1);
            last_dir_d = DOWN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_req_q   <= '0;
            dn_req_q   <= '0;
            car_req_q  <= '0;
            floor_q    <= '0;
            arrive_q   <= 1'b0;
            last_dir_q <= IDLE;
        end else begin
            up_req_q   <= up_req_d;
            dn_req_q   <= dn_req_d;
            car_req_q  <= car_req_d;
            floor_q    <= floor_d;
            arrive_q   <= arrive_d;
            last_dir_q <= last_dir_d;
        end
    end

    // Summary flags, purely from registered state.
    always_comb begin
        pend   = up_req_q | dn_req_q | car_req_q;
        gt_any = 1'b0;
        lt_any = 1'b0;
        for (int k = 0; k < N_FLOORS; k++) begin
            if (FW'(k) > floor_q) gt_any = gt_any | pend[k];
            if (FW'(k) < floor_q) lt_any = lt_any | pend[k];
        end
    end

    assign floor_number   = floor_q;
    assign arrive         = arrive_q;
    assign request_i      = |(pend & floor_onehot);
    assign request_j_gt_i = gt_any;
    assign request_j_lt_i = lt_any;

endmodule
